seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Parametrised multiplexed seven-segment scan controller; successor to the fixed 8-digit driver on the board display path. Time-multiplexes N_DIGITS digits from a packed data word in hex-decode or raw-segment mode. Adds double-buffered tear-free loading, per-digit decimal point, blanking and blink, leading-zero suppression, 16-level PWM brightness, and a frame-boundary strobe. Sits between the CPU/debug register file and the board pins.

## Interface
- N_DIGITS, 8: digit count, 2..16.
- SCAN_DIV, 16384: clk cycles per digit slot; power of two, ≥16.
- BLINK_FRAMES, 32: frames per blink half-period, ≥1.
- clk  in  1  system clock.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- disp_mode  in  1  0 = hex decode (nibble per digit), 1 = raw segment byte per digit.
- i_data  in  8*N_DIGITS  display data; hex mode uses bits [4*N_DIGITS-1:0].
- i_load  in  1  capture i_data (with the mask inputs) into the staging buffer.
- i_dp_mask  in  N_DIGITS  decimal point on per digit; hex mode only.
- i_blank  in  N_DIGITS  force digit dark.
- i_blink  in  N_DIGITS  digit dark during blink off-phase.
- i_lz_en  in  1  leading-zero suppression, hex mode only.
- i_bright  in  4  brightness 0..15; 15 = full slot.
- o_seg  out  8  segments {dp,g..a}, active low.
- o_sel  out  N_DIGITS  digit enables, active low, one-cold.
- o_frame  out  1  one-cycle pulse at frame boundary.

## Operation
- Prescaler pre counts 0..SCAN_DIV-1, wraps. Digit index dig advances at pre = SCAN_DIV-1; wraps N_DIGITS-1 → 0.
- Frame boundary: pre terminal and dig = N_DIGITS-1.
- Staging buffer: i_load = 1 writes i_data, i_dp_mask, i_blank, i_blink into it. Display buffer takes staging at frame boundary only. If i_load coincides with the boundary, display takes i_data directly. No partial frame ever shown.
- disp_mode and i_lz_en/i_bright act live, not buffered.
- Hex mode: nibble = disp[4*dig+3:4*dig] → font 0–F (c0,f9,a4,b0,99,92,82,f8,80,90,88,83,c6,a1,86,8e). dp: bit7 cleared when dp_mask[dig].
- Raw mode: o_seg = disp byte dig verbatim; dp_mask ignored.
- Leading-zero suppression (hex, i_lz_en): digit k is dark if all nibbles k..N_DIGITS-1 are 0. Digit 0 is never suppressed.
- Blink: frame counter 0..BLINK_FRAMES-1; phase toggles at wrap. Phase resets to on. During off-phase, digits with blink bit set are dark.
- PWM: ph = pre[log2(SCAN_DIV)-1 -: 4]. o_sel active only while ph ≤ i_bright.
- Dark digit (blank, blink-off, LZ, or PWM-off): o_sel all ones and o_seg = ff.

## Timing
- Reset: o_seg = 8'hff, o_sel all ones, o_frame = 0, pre = 0, dig = 0, both buffers 0, blink phase on.
- o_seg and o_sel registered from the same dig/pre state, so they are always aligned. One clk latency from state to pins.
- Digit slot = SCAN_DIV cycles. Frame = N_DIGITS*SCAN_DIV cycles.
- o_frame is high in the cycle after the boundary, i.e. the first registered output of digit 0 with new display data.
- Reset mid-frame: immediate return to reset values; scanning restarts at digit 0.

## Structure
- Package seg7_pkg: SEG_OFF = 8'hff, 16-entry hex font constant, mode encodings.
- Sub-module seg7_hex_font: combinational nibble → 7-bit pattern.
- Remaining logic (prescaler, buffers, LZ, blink, PWM, output regs) lives in the top module.

## Test plan
- Test config: SCAN_DIV = 16, N_DIGITS = 8, BLINK_FRAMES = 2 throughout.
- Hex, load 32'h0000_12AF, bright 15 → per slot: sel fe/fd/fb/f7 show 8e/88/a4/f9; digits 4..7 show c0. With i_lz_en: digits 4..7 dark, digit 0 still shown for data 0.
- i_load of a new value mid-frame → pins unchanged until the o_frame pulse, then new data from digit 0. i_load on the boundary cycle → new data in that same frame.
- Raw mode, byte 0 = 8'h7f, dp_mask = 1 → o_seg = 7f on digit 0; dp_mask has no effect.
- i_bright = 3 → each slot's o_sel active for 4 of 16 cycles (pre 0..3); o_seg = ff otherwise.
- i_blink = 8'h01 → digit 0 dark for 2 frames, lit for 2, repeating; i_blank = 8'h80 → digit 7 always dark. Assert rstn low mid-slot → outputs ff / all ones at once.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: blank pattern,
// hex font (active-low {dp,g..a}) and display mode encodings.
package seg7_pkg;

  // All segments and the decimal point off (active low).
  localparam logic [7:0] SEG_OFF = 8'hff;

  // Hex font, entry n is the pattern for nibble n; bit 7 (dp) is off in every entry.
  localparam logic [15:0][7:0] HEX_FONT = {
    8'h8e, 8'h86, 8'ha1, 8'hc6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hf8, 8'h82, 8'h92, 8'h99, 8'hb0, 8'ha4, 8'hf9, 8'hc0
  };

  // Display mode: hex decode of one nibble per digit, or a raw segment byte per digit.
  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_RAW = 1'b1
  } disp_mode_e;

endpackage

// File: rtl/seg7_hex_font.sv
// Combinational hex font lookup: nibble to seven active-low segments {g..a}.
module seg7_hex_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg7
);

  // Table lookup; the dp bit is handled by the caller.
  always_comb begin
    seg7 = HEX_FONT[nibble][6:0];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller. A prescaler paces digit slots,
// a double buffer (staging -> display at frame boundary) keeps frames
// tear-free, and blanking, blink, leading-zero suppression and PWM brightness
// decide whether the current digit is lit.
//
// The pin registers are loaded from the next-state values (pre_d, dig_d,
// disp_*_d), so the pins always show the digit held in dig_q/pre_q, and the
// cycle in which o_frame is high is the first one showing digit 0 with the
// freshly transferred display data.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int SCAN_DIV     = 16384,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  disp_mode,
  input  logic [8*N_DIGITS-1:0] i_data,
  input  logic                  i_load,
  input  logic [N_DIGITS-1:0]   i_dp_mask,
  input  logic [N_DIGITS-1:0]   i_blank,
  input  logic [N_DIGITS-1:0]   i_blink,
  input  logic                  i_lz_en,
  input  logic [3:0]            i_bright,
  output logic [7:0]            o_seg,
  output logic [N_DIGITS-1:0]   o_sel,
  output logic                  o_frame
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int DIG_W = $clog2(N_DIGITS);
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(N_DIGITS - 1);
  localparam logic [FR_W-1:0]  FR_MAX  = FR_W'(BLINK_FRAMES - 1);

  // Scan position
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic             pre_wrap, boundary;

  // Staging and display buffers
  logic [8*N_DIGITS-1:0] stg_data_q, stg_data_d, disp_data_q, disp_data_d;
  logic [N_DIGITS-1:0]   stg_dp_q, stg_dp_d, disp_dp_q, disp_dp_d;
  logic [N_DIGITS-1:0]   stg_blank_q, stg_blank_d, disp_blank_q, disp_blank_d;
  logic [N_DIGITS-1:0]   stg_blink_q, stg_blink_d, disp_blink_q, disp_blink_d;

  // Blink timing
  logic [FR_W-1:0] fcnt_q, fcnt_d;
  logic            blink_on_q, blink_on_d;

  // Pin registers
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] sel_q, sel_d;
  logic                frame_q, frame_d;

  // Output datapath helpers
  logic [6:0]          font7;
  logic [3:0]          nib;
  logic [7:0]          lit_seg;
  logic [3:0]          ph;
  logic [N_DIGITS-1:0] lz_dark;
  logic                all_zero;
  logic                dark;

  // Prescaler and digit index advance; boundary marks the last cycle of a frame.
  always_comb begin
    pre_wrap = (pre_q == PRE_MAX);
    boundary = pre_wrap && (dig_q == DIG_MAX);
    pre_d    = pre_wrap ? '0 : pre_q + 1'b1;
    dig_d    = dig_q;
    if (pre_wrap) begin
      dig_d = (dig_q == DIG_MAX) ? '0 : dig_q + 1'b1;
    end
  end

  // Staging captures on load; display takes staging (or a coincident load) only at the boundary.
  always_comb begin
    stg_data_d   = i_load ? i_data    : stg_data_q;
    stg_dp_d     = i_load ? i_dp_mask : stg_dp_q;
    stg_blank_d  = i_load ? i_blank   : stg_blank_q;
    stg_blink_d  = i_load ? i_blink   : stg_blink_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    disp_blink_d = disp_blink_q;
    if (boundary) begin
      disp_data_d  = stg_data_d;
      disp_dp_d    = stg_dp_d;
      disp_blank_d = stg_blank_d;
      disp_blink_d = stg_blink_d;
    end
  end

  // Frame counter for blink; phase flips each time the counter wraps.
  always_comb begin
    fcnt_d     = fcnt_q;
    blink_on_d = blink_on_q;
    if (boundary) begin
      if (fcnt_q == FR_MAX) begin
        fcnt_d     = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Leading-zero map: digit k is dark when nibbles k..top are all zero; digit 0 never.
  always_comb begin
    lz_dark  = '0;
    all_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero & (disp_data_d[4*k +: 4] == 4'h0);
      lz_dark[k] = all_zero;
    end
  end

  seg7_hex_font u_font (
    .nibble (nib),
    .seg7   (font7)
  );

  // Pin values for the next scan position: pick the pattern, then apply all dark conditions.
  always_comb begin
    nib = disp_data_d[4*dig_d +: 4];
    ph  = pre_d[PRE_W-1 -: 4];
    if (disp_mode_e'(disp_mode) == MODE_RAW) begin
      lit_seg = disp_data_d[8*dig_d +: 8];
    end else begin
      lit_seg = {~disp_dp_d[dig_d], font7};
    end
    dark = disp_blank_d[dig_d]
         | (disp_blink_d[dig_d] & ~blink_on_d)
         | ((disp_mode_e'(disp_mode) == MODE_HEX) & i_lz_en & lz_dark[dig_d])
         | (ph > i_bright);
    seg_d   = dark ? SEG_OFF : lit_seg;
    sel_d   = dark ? '1 : ~(N_DIGITS'(1) << dig_d);
    frame_d = boundary;
  end

  // State and pin registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_q        <= '0;
      dig_q        <= '0;
      stg_data_q   <= '0;
      stg_dp_q     <= '0;
      stg_blank_q  <= '0;
      stg_blink_q  <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      disp_blink_q <= '0;
      fcnt_q       <= '0;
      blink_on_q   <= 1'b1;
      seg_q        <= SEG_OFF;
      sel_q        <= '1;
      frame_q      <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      dig_q        <= dig_d;
      stg_data_q   <= stg_data_d;
      stg_dp_q     <= stg_dp_d;
      stg_blank_q  <= stg_blank_d;
      stg_blink_q  <= stg_blink_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      disp_blink_q <= disp_blink_d;
      fcnt_q       <= fcnt_d;
      blink_on_q   <= blink_on_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_q      <= frame_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_sel   = sel_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (N_DIGITS=8, SCAN_DIV=16, BLINK_FRAMES=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seg7_scan_ctrl;

  localparam int N  = 8;
  localparam int SD = 16;
  localparam int BF = 2;

  logic         clk;
  logic         rstn;
  logic         disp_mode;
  logic [63:0]  i_data;
  logic         i_load;
  logic [7:0]   i_dp_mask;
  logic [7:0]   i_blank;
  logic [7:0]   i_blink;
  logic         i_lz_en;
  logic [3:0]   i_bright;
  logic [7:0]   o_seg;
  logic [7:0]   o_sel;
  logic         o_frame;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {sel, seg} per digit for one scanned frame.
  logic [15:0] exp_q[$];

  seg7_scan_ctrl #(
    .N_DIGITS     (N),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .disp_mode (disp_mode),
    .i_data    (i_data),
    .i_load    (i_load),
    .i_dp_mask (i_dp_mask),
    .i_blank   (i_blank),
    .i_blink   (i_blink),
    .i_lz_en   (i_lz_en),
    .i_bright  (i_bright),
    .o_seg     (o_seg),
    .o_sel     (o_sel),
    .o_frame   (o_frame)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [63:0] d, input logic [7:0] dp,
                      input logic [7:0] blank, input logic [7:0] blink);
    i_data    = d;
    i_dp_mask = dp;
    i_blank   = blank;
    i_blink   = blink;
    i_load    = 1'b1;
    step(1);
    i_load    = 1'b0;
  endtask

  // Advance to the next frame pulse (pins then show digit 0, slot cycle 0).
  task automatic sync_frame();
    int n;
    n = 0;
    step(1);
    while (o_frame !== 1'b1 && n < 300) begin
      step(1);
      n++;
    end
    chk("frame_sync", {31'd0, o_frame}, 32'd1);
  endtask

  function automatic logic [7:0] lit_sel(input int k);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << k);
  endfunction

  task automatic push_dig(input logic [7:0] sel, input logic [7:0] seg);
    exp_q.push_back({sel, seg});
  endtask

  // Scoreboard: compare the middle of every digit slot of the next frame with exp_q.
  task automatic scan_frame(input string tag);
    logic [15:0] e;
    sync_frame();
    step(8);
    for (int k = 0; k < N; k++) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s_d%0d_seg", tag, k), {24'd0, o_seg}, {24'd0, e[7:0]});
        chk($sformatf("%s_d%0d_sel", tag, k), {24'd0, o_sel}, {24'd0, e[15:8]});
      end
      if (k < N - 1) step(SD);
    end
    exp_q.delete();
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rstn      = 1'b0;
    disp_mode = 1'b0;
    i_data    = '0;
    i_load    = 1'b0;
    i_dp_mask = '0;
    i_blank   = '0;
    i_blink   = '0;
    i_lz_en   = 1'b0;
    i_bright  = 4'd15;
    step(3);
    chk("reset_seg",   {24'd0, o_seg},   32'hff);
    chk("reset_sel",   {24'd0, o_sel},   32'hff);
    chk("reset_frame", {31'd0, o_frame}, 32'd0);
    rstn = 1'b1;

    // Hex decode of 0x12AF
    load(64'h0000_12AF, 8'h00, 8'h00, 8'h00);
    push_dig(lit_sel(0), 8'h8e);
    push_dig(lit_sel(1), 8'h88);
    push_dig(lit_sel(2), 8'ha4);
    push_dig(lit_sel(3), 8'hf9);
    for (int k = 4; k < N; k++) push_dig(lit_sel(k), 8'hc0);
    scan_frame("hex");

    // Frame pulse lasts one cycle
    sync_frame();
    step(1);
    chk("frame_width", {31'd0, o_frame}, 32'd0);

    // Leading-zero suppression on 0x12AF
    i_lz_en = 1'b1;
    push_dig(lit_sel(0), 8'h8e);
    push_dig(lit_sel(1), 8'h88);
    push_dig(lit_sel(2), 8'ha4);
    push_dig(lit_sel(3), 8'hf9);
    for (int k = 4; k < N; k++) push_dig(8'hff, 8'hff);
    scan_frame("lz");

    // Leading-zero suppression on all-zero data keeps digit 0
    load(64'h0, 8'h00, 8'h00, 8'h00);
    push_dig(lit_sel(0), 8'hc0);
    for (int k = 1; k < N; k++) push_dig(8'hff, 8'hff);
    scan_frame("lz_zero");
    i_lz_en = 1'b0;

    // Mid-frame load is held back until the next frame
    sync_frame();
    step(2 * SD + 8);
    load(64'h7777_7777, 8'h00, 8'h00, 8'h00);
    step(5 * SD + 8 - (2 * SD + 9));
    chk("midload_old_seg", {24'd0, o_seg}, 32'hc0);
    chk("midload_old_sel", {24'd0, o_sel}, {24'd0, lit_sel(5)});
    sync_frame();
    step(8);
    chk("midload_new_seg", {24'd0, o_seg}, 32'hf8);
    chk("midload_new_sel", {24'd0, o_sel}, {24'd0, lit_sel(0)});

    // Load on the boundary cycle goes straight to the display
    sync_frame();
    step(N * SD - 1);
    chk("bnd_last_seg", {24'd0, o_seg}, 32'hf8);
    chk("bnd_last_sel", {24'd0, o_sel}, {24'd0, lit_sel(7)});
    load(64'h3333_3333, 8'h00, 8'h00, 8'h00);
    chk("bnd_frame", {31'd0, o_frame}, 32'd1);
    chk("bnd_seg",   {24'd0, o_seg},   32'hb0);
    chk("bnd_sel",   {24'd0, o_sel},   {24'd0, lit_sel(0)});

    // Raw mode: bytes verbatim, dp mask ignored
    disp_mode = 1'b1;
    load({48'h0, 8'hc0, 8'h7f}, 8'h03, 8'h00, 8'h00);
    push_dig(lit_sel(0), 8'h7f);
    push_dig(lit_sel(1), 8'hc0);
    for (int k = 2; k < N; k++) push_dig(lit_sel(k), 8'h00);
    scan_frame("raw");

    // Same buffer in hex mode (mode acts live): dp cleared on digits 0 and 1
    disp_mode = 1'b0;
    push_dig(lit_sel(0), 8'h0e);
    push_dig(lit_sel(1), 8'h78);
    push_dig(lit_sel(2), 8'hc0);
    push_dig(lit_sel(3), 8'hc6);
    for (int k = 4; k < N; k++) push_dig(lit_sel(k), 8'hc0);
    scan_frame("hex_dp");

    // PWM brightness 3: lit for slot cycles 0..3 only
    load(64'h0000_12AF, 8'h00, 8'h00, 8'h00);
    i_bright = 4'd3;
    sync_frame();
    for (int p = 0; p < SD; p++) begin
      chk($sformatf("pwm_p%0d_sel", p), {24'd0, o_sel}, (p <= 3) ? 32'hfe : 32'hff);
      chk($sformatf("pwm_p%0d_seg", p), {24'd0, o_seg}, (p <= 3) ? 32'h8e : 32'hff);
      step(1);
    end
    i_bright = 4'd15;

    // Asynchronous reset in the middle of a slot
    sync_frame();
    step(3 * SD + 5);
    chk("prerst_seg", {24'd0, o_seg}, 32'hf9);
    chk("prerst_sel", {24'd0, o_sel}, {24'd0, lit_sel(3)});
    #1;
    rstn = 1'b0;
    #1;
    chk("rst_async_seg",   {24'd0, o_seg},   32'hff);
    chk("rst_async_sel",   {24'd0, o_sel},   32'hff);
    chk("rst_async_frame", {31'd0, o_frame}, 32'd0);
    step(2);
    rstn = 1'b1;

    // Blink on digit 0 (2 frames on, 2 off), blank on digit 7
    load(64'h0000_12AF, 8'h00, 8'h80, 8'h01);
    for (int f = 1; f <= 5; f++) begin
      sync_frame();
      step(8);
      chk($sformatf("blink_f%0d_seg", f), {24'd0, o_seg},
          (((f / BF) % 2) == 0) ? 32'h8e : 32'hff);
      chk($sformatf("blink_f%0d_sel", f), {24'd0, o_sel},
          (((f / BF) % 2) == 0) ? 32'hfe : 32'hff);
      step(SD);
      chk($sformatf("blink_f%0d_d1", f), {24'd0, o_seg}, 32'h88);
      step(6 * SD);
      chk($sformatf("blank_f%0d_seg", f), {24'd0, o_seg}, 32'hff);
      chk($sformatf("blank_f%0d_sel", f), {24'd0, o_sel}, 32'hff);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
